// File: rtl/io_key_device_pkg.sv
// Shared definitions for the KEY peripheral: KCTRL bit layout and the status-flag bundle.
// Bus protocol: single-cycle loads/stores, no handshake; a load is combinational on addr and commits on the clock edge.
package io_key_device_pkg;

  localparam int KCTRL_READY   = 0;
  localparam int KCTRL_OVERRUN = 2;
  localparam int KCTRL_IE      = 8;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } key_status_t;

endpackage

// File: rtl/io_key_device_key_debouncer.sv
// Two-flop synchronizer followed by a whole-vector debouncer; 'changed' pulses on the
// same edge that the settled vector is loaded, so consumers can act on it in that cycle.
module key_debouncer #(
  parameter int WIDTH        = 4,
  parameter int COUNTER_SIZE = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]        sync1;
  logic [WIDTH-1:0]        sync_key;
  logic [COUNTER_SIZE-1:0] cnt;

  assign changed = (sync_key != stable) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync_key <= '0;
      cnt      <= '0;
      stable   <= '0;
    end else begin
      sync1    <= key;
      sync_key <= sync1;
      // Returning to the settled value at any point discards the partial count.
      if (sync_key == stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        stable <= sync_key;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/io_key_device.sv
// Memory-mapped KEY peripheral: debounced key data register plus a control/status
// register with ready, overrun and interrupt-enable bits.
module io_key_device
  import io_key_device_pkg::*;
#(
  parameter int              DBITS                  = 32,
  parameter int              KEYBITS                = 4,
  parameter logic [DBITS-1:0] ADDR_KDATA            = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_KCTRL            = 32'hF0000110,
  parameter int              DEBOUNCER_COUNTER_SIZE = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DBITS-1:0]   addr,
  input  logic [DBITS-1:0]   dataIn,
  input  logic               loadStore,
  input  logic               rdEn,
  input  logic [KEYBITS-1:0] KEY,
  output logic [DBITS-1:0]   dataOut,
  output logic               hit,
  output logic               intr
);

  logic [KEYBITS-1:0] kdata;
  logic               changed;
  key_status_t        status;

  logic data_hit;
  logic ctrl_hit;
  logic ctrl_wr;
  logic data_rd;

  key_debouncer #(
    .WIDTH        (KEYBITS),
    .COUNTER_SIZE (DEBOUNCER_COUNTER_SIZE)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .key     (KEY),
    .stable  (kdata),
    .changed (changed)
  );

  assign data_hit = (addr == ADDR_KDATA);
  assign ctrl_hit = (addr == ADDR_KCTRL);
  assign hit      = data_hit | ctrl_hit;
  assign ctrl_wr  = loadStore & ctrl_hit;
  // A simultaneous store suppresses the load's side effect.
  assign data_rd  = rdEn & ~loadStore & data_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= '0;
    end else begin
      if (ctrl_wr) begin
        status.ie      <= dataIn[KCTRL_IE];
        status.overrun <= status.overrun & dataIn[KCTRL_OVERRUN];
      end
      // A settled change always wins over a concurrent clear of ready or overrun.
      if (changed) begin
        if (status.ready) begin
          status.overrun <= 1'b1;
        end else begin
          status.ready <= 1'b1;
        end
      end else if (data_rd) begin
        status.ready <= 1'b0;
      end
    end
  end

  always_comb begin
    dataOut = '0;
    if (data_hit) begin
      dataOut[KEYBITS-1:0] = kdata;
    end else if (ctrl_hit) begin
      dataOut[KCTRL_READY]   = status.ready;
      dataOut[KCTRL_OVERRUN] = status.overrun;
      dataOut[KCTRL_IE]      = status.ie;
    end
  end

  assign intr = status.ready & status.ie;

  logic unused_din;
  assign unused_din = ^{dataIn[DBITS-1:KCTRL_IE+1], dataIn[KCTRL_IE-1:KCTRL_OVERRUN+1],
                        dataIn[KCTRL_OVERRUN-1:0]};

endmodule

// File: tb/tb_io_key_device.sv
// Bench for io_key_device with a 2-cycle settle time: directed scenarios then random traffic,
// every cycle's read checked against a behavioural model through an expected queue.
module tb_io_key_device;

  localparam int DBITS   = 32;
  localparam int KEYBITS = 4;
  localparam int CS      = 1;
  localparam int SETTLE  = 1 << CS;
  localparam int W       = DBITS + 2;
  localparam logic [31:0] A_KDATA = 32'hF0000010;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_OTHER = 32'hF0000014;

  logic               clk;
  logic               reset;
  logic [DBITS-1:0]   addr;
  logic [DBITS-1:0]   dataIn;
  logic               loadStore;
  logic               rdEn;
  logic [KEYBITS-1:0] KEY;
  logic [DBITS-1:0]   dataOut;
  logic               hit;
  logic               intr;

  io_key_device #(
    .DBITS                  (DBITS),
    .KEYBITS                (KEYBITS),
    .ADDR_KDATA             (A_KDATA),
    .ADDR_KCTRL             (A_KCTRL),
    .DEBOUNCER_COUNTER_SIZE (CS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .dataIn    (dataIn),
    .loadStore (loadStore),
    .rdEn      (rdEn),
    .KEY       (KEY),
    .dataOut   (dataOut),
    .hit       (hit),
    .intr      (intr)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pin history, settled value, mismatch run length, status flags
  logic [3:0] m_s1, m_s2, m_kdata;
  int         m_run;
  bit         m_ready, m_ovr, m_ie;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   addr_q[$];
  int            checks = 0;
  int            passes = 0;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_kdata = '0; m_run = 0;
    m_ready = 0; m_ovr = 0; m_ie = 0;
  endtask

  function automatic logic [W-1:0] model_read(input logic [31:0] a);
    logic [31:0] d;
    logic        h;
    d = '0;
    h = 1'b0;
    if (a == A_KDATA) begin
      d = {28'b0, m_kdata};
      h = 1'b1;
    end else if (a == A_KCTRL) begin
      d[0] = m_ready;
      d[2] = m_ovr;
      d[8] = m_ie;
      h = 1'b1;
    end
    return {d, h, m_ready & m_ie};
  endfunction

  task automatic model_step(input logic rst, input logic [31:0] a, input logic [31:0] din,
                            input logic ls, input logic rd, input logic [3:0] key);
    bit changed;
    bit was_ready;
    if (rst) begin
      model_reset();
      return;
    end
    changed   = 0;
    was_ready = m_ready;
    // The settled value follows once the synchronized pins have differed for SETTLE edges in a row.
    if (m_s2 != m_kdata) begin
      m_run++;
      if (m_run == SETTLE) begin
        m_kdata = m_s2;
        m_run   = 0;
        changed = 1;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = key;
    if (ls && a == A_KCTRL) begin
      m_ie  = din[8];
      m_ovr = m_ovr & din[2];
    end
    if (changed) begin
      if (was_ready) m_ovr = 1;
      else           m_ready = 1;
    end else if (rd && !ls && a == A_KDATA) begin
      m_ready = 0;
    end
  endtask

  // Driver: apply one cycle of bus/pin inputs, queue the expected read, advance the model
  task automatic cycle(input logic rst, input logic [31:0] a, input logic [31:0] din,
                       input logic ls, input logic rd, input logic [3:0] key);
    reset = rst; addr = a; dataIn = din; loadStore = ls; rdEn = rd; KEY = key;
    if (rst) model_reset();
    exp_q.push_back(model_read(a));
    addr_q.push_back(a);
    @(posedge clk);
    #1;
    model_step(rst, a, din, ls, rd, key);
  endtask

  task automatic idle(input int n, input logic [31:0] a, input logic [3:0] key);
    for (int i = 0; i < n; i++) cycle(1'b0, a, 32'h0, 1'b0, 1'b0, key);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] exp;
    logic [W-1:0] act;
    logic [31:0]  a;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      a   = addr_q.pop_front();
      act = {dataOut, hit, intr};
      checks++;
      if (act !== exp)
        $display("FAIL read@%h: got data=%h hit=%b intr=%b, expected data=%h hit=%b intr=%b",
                 a, act[W-1:2], act[1], act[0], exp[W-1:2], exp[1], exp[0]);
      else
        passes++;
    end
  end

  // Stimulus
  initial begin
    logic [3:0]  rkey;
    logic [31:0] ra;
    logic [31:0] rdin;
    int          hold;
    int          r;
    logic        rls, rrd, rrst;

    reset = 1'b1; addr = '0; dataIn = '0; loadStore = 1'b0; rdEn = 1'b0; KEY = 4'hF;
    model_reset();
    @(posedge clk);
    #1;

    // Reset with keys held high, then release and let them settle
    cycle(1'b1, A_KDATA, 0, 0, 0, 4'hF);
    cycle(1'b1, A_KCTRL, 0, 0, 0, 4'hF);
    idle(5, A_KCTRL, 4'hF);
    idle(1, A_KDATA, 4'hF);

    // Clear ready, settle a new pattern, load it
    cycle(1'b0, A_KDATA, 0, 0, 1, 4'hF);
    idle(5, A_KCTRL, 4'hA);
    idle(1, A_KDATA, 4'hA);
    cycle(1'b0, A_KDATA, 0, 0, 1, 4'hA);
    idle(1, A_KCTRL, 4'hA);

    // Single-cycle glitch must not update
    idle(5, A_KCTRL, 4'h0);
    cycle(1'b0, A_KDATA, 0, 0, 1, 4'h0);
    cycle(1'b0, A_KCTRL, 0, 0, 0, 4'h1);
    idle(5, A_KCTRL, 4'h0);
    idle(5, A_KDATA, 4'h0);

    // Two unread changes -> overrun; clearing store keeps ready
    idle(5, A_KCTRL, 4'h3);
    idle(5, A_KCTRL, 4'h5);
    cycle(1'b0, A_KDATA, 32'hFFFF_FFFF, 1, 0, 4'h5);
    cycle(1'b0, A_KCTRL, 32'h0, 1, 0, 4'h5);
    idle(2, A_KCTRL, 4'h5);

    // Interrupt enable, then a load drops intr
    cycle(1'b0, A_KCTRL, 32'h100, 1, 0, 4'h5);
    cycle(1'b0, A_KDATA, 0, 0, 1, 4'h5);
    idle(5, A_KCTRL, 4'h6);
    cycle(1'b0, A_KDATA, 0, 0, 1, 4'h6);
    idle(2, A_KCTRL, 4'h6);

    // Change settling on the edge of a load: ready survives
    idle(3, A_KCTRL, 4'h9);
    cycle(1'b0, A_KDATA, 0, 0, 1, 4'h9);
    idle(2, A_KCTRL, 4'h9);
    // Change settling on the edge of an overrun-clearing store: overrun survives
    idle(3, A_KCTRL, 4'h4);
    cycle(1'b0, A_KCTRL, 32'h100, 1, 0, 4'h4);
    idle(2, A_KCTRL, 4'h4);
    // Load and store together: store applies, ready stays
    cycle(1'b0, A_KDATA, 0, 1, 1, 4'h4);
    idle(1, A_KCTRL, 4'h4);

    // Reset in the middle of a debounce
    idle(2, A_KCTRL, 4'h2);
    cycle(1'b1, A_KDATA, 0, 0, 0, 4'h2);
    cycle(1'b1, A_KCTRL, 0, 0, 0, 4'h2);
    idle(6, A_KCTRL, 4'h2);

    // Random traffic
    hold = 0;
    rkey = 4'h0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        rkey = 4'($urandom);
        hold = $urandom_range(1, 6);
      end
      hold--;
      case ($urandom_range(0, 2))
        0:       ra = A_KDATA;
        1:       ra = A_KCTRL;
        default: ra = ($urandom_range(0, 1) == 0) ? A_OTHER : $urandom;
      endcase
      r    = $urandom_range(0, 19);
      rrd  = (r < 6) || (r == 19);
      rls  = (r >= 6 && r < 10) || (r == 19);
      rdin = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom_range(0, 3) << 7) | ($urandom_range(0, 1) << 2);
      rrst = ($urandom_range(0, 199) == 0);
      cycle(rrst, ra, rdin, rls, rrd, rkey);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d reads left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
